cacheline_adaptor: RTL and testbench
====================================

Name: cacheline_adaptor

Overview:
- Responder side of the cache's line-level memory interface.
- Accepts one 256-bit line read or write request at a time from the cache (line_i/address_i/read_i/write_i in, line_o/resp_o out).
- Converts each request into a 4-beat, 64-bit burst transaction on the physical-memory port.
- Sits between the cache and main memory / arbiter; returns one single-cycle resp_o per completed line.

Parameters:
- s_line, 256, cache line width in bits.
- s_burst, 64, memory burst beat width in bits.
- num_beats, s_line/s_burst (4), beats per line.
- s_offset, 5, line offset bits cleared in the burst address.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- line_i  input  256  write line from cache; beat k = bits [64k+63:64k].
- line_o  output  256  assembled read line to cache.
- address_i  input  32  line address from cache.
- read_i  input  1  cache line read request.
- write_i  input  1  cache line write request.
- resp_o  output  1  one-cycle completion pulse to cache.
- burst_i  input  64  read beat from memory.
- burst_o  output  64  write beat to memory.
- address_o  output  32  burst address to memory.
- read_o  output  1  memory burst read request.
- write_o  output  1  memory burst write request.
- resp_i  input  1  memory beat handshake; one beat transferred per cycle it is high.

Behaviour:
- States: IDLE, READ, WRITE, DONE. Beat counter is 2 bits, range 0..num_beats-1.
- Reset values: state=IDLE, counter=0, resp_o=0, read_o=0, write_o=0, address_o=0, burst_o=0, line_o=0.
- Reset asserted mid-burst aborts the transaction: all of the above values apply on the next edge, and no resp_o is produced.
- IDLE, request capture:
  - Samples read_i/write_i every cycle.
  - Captures {address_i[31:s_offset], s_offset'b0} into address_o and clears the counter.
  - write_i=1 → WRITE; also captures line_i into a 256-bit write buffer.
  - read_i=1 (write_i=0) → READ.
  - Both high at once: write wins; the read is not served and the cache must re-request.
  - resp_i in IDLE or DONE is ignored.
- READ:
  - read_o=1 for the whole state; address_o held.
  - Each cycle with resp_i=1: burst_i is written into line_o bits [64*counter+63:64*counter], then counter increments.
  - Cycles with resp_i=0 stall with no state change; beats need not be consecutive.
  - On the beat with counter=3 and resp_i=1 → DONE; read_o drops on entering DONE.
- WRITE:
  - write_o=1 for the whole state.
  - burst_o = write buffer beat[counter], combinational from the counter, so beat 0 is presented in the first WRITE cycle.
  - Each resp_i=1 advances the counter.
  - After beat 3 is accepted → DONE; write_o drops on entering DONE.
- DONE:
  - resp_o=1 for exactly this one cycle.
  - line_o is fully assembled during this cycle after a read.
  - Next state is IDLE unconditionally. A request still held by the cache during DONE is not re-captured, because the cache deasserts in the cycle after resp_o.
- line_o holds its value after DONE until the next read overwrites it beat by beat; it is not changed by writes.
- Latency with back-to-back resp_i: request sampled at cycle 0, beats at cycles 1-4, resp_o at cycle 5.
- Each stall cycle adds one cycle of latency.
- address_o stays stable from capture until the next request capture; it is not cleared in IDLE.

Test Plan:
- Reset → all outputs 0, state IDLE; resp_i pulses while idle give resp_o=0 and read_o=write_o=0.
- Read, addr 0x0000_1234, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles:
  - address_o=0x0000_1220; read_o high cycles 1-4.
  - resp_o high in cycle 5 only.
  - line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write, line_i = {64'hD, 64'hC, 64'hB, 64'hA}, addr 0x8000_0040, resp_i high with 2-cycle gaps:
  - burst_o shows A, B, C, D in order, each held until its resp_i.
  - write_o is high throughout the burst.
  - Exactly one resp_o, after the 4th beat.
- read_i and write_i asserted together → WRITE path taken, read_o never asserted.
- rst asserted after 2 read beats → next cycle IDLE, read_o=0, line_o=0, no resp_o; a following fresh read completes normally.
- Cache holds read_i high through the resp_o cycle and drops it next cycle → exactly one burst issued, no second read_o.

Source files
------------

// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - cache line to 4-beat memory burst adaptor
module cacheline_adaptor #(
    parameter int s_line    = 256,
    parameter int s_burst   = 64,
    parameter int num_beats = s_line / s_burst,
    parameter int s_offset  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [s_line-1:0]   line_i,
    output logic [s_line-1:0]   line_o,
    input  logic [31:0]         address_i,
    input  logic                read_i,
    input  logic                write_i,
    output logic                resp_o,
    input  logic [s_burst-1:0]  burst_i,
    output logic [s_burst-1:0]  burst_o,
    output logic [31:0]         address_o,
    output logic                read_o,
    output logic                write_o,
    input  logic                resp_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] LAST_BEAT = 2'(num_beats - 1);

    state_t              r_state;
    logic [1:0]          r_count;
    logic [s_line-1:0]   r_wbuf;
    logic                w_unused_addr_bits;

    // Offset bits are cleared in the burst address, so they are never consumed.
    assign w_unused_addr_bits = ^address_i[s_offset-1:0];

    // Write data is selected straight from the counter so beat 0 is valid in the first WRITE cycle.
    assign burst_o = r_wbuf[s_burst*r_count +: s_burst];

    // Request capture, beat sequencing and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_count   <= 2'd0;
            r_wbuf    <= '0;
            resp_o    <= 1'b0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            address_o <= 32'd0;
            line_o    <= '0;
        end else begin
            resp_o <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_count <= 2'd0;
                    if (write_i) begin
                        // Write wins when both requests arrive together.
                        address_o <= {address_i[31:s_offset], {s_offset{1'b0}}};
                        r_wbuf    <= line_i;
                        write_o   <= 1'b1;
                        r_state   <= WRITE;
                    end else if (read_i) begin
                        address_o <= {address_i[31:s_offset], {s_offset{1'b0}}};
                        read_o    <= 1'b1;
                        r_state   <= READ;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        line_o[s_burst*r_count +: s_burst] <= burst_i;
                        r_count <= r_count + 2'd1;
                        if (r_count == LAST_BEAT) begin
                            read_o  <= 1'b0;
                            resp_o  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                WRITE: begin
                    if (resp_i) begin
                        r_count <= r_count + 2'd1;
                        if (r_count == LAST_BEAT) begin
                            write_o <= 1'b0;
                            resp_o  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // The cache drops its request after seeing resp_o, so never re-capture here.
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb/tb_cacheline_adaptor.sv - directed self-checking bench for cacheline_adaptor
module tb_cacheline_adaptor;

    logic         clk;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int passed;
    int total;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++;
        if ({resp_o, read_o, write_o} !== 3'b000) $display("FAIL reset_ctrl got %b want 000", {resp_o, read_o, write_o});
        else passed++;
        total++;
        if (address_o !== 32'd0) $display("FAIL reset_addr got %h want 0", address_o);
        else passed++;
        total++;
        if (burst_o !== 64'd0) $display("FAIL reset_burst got %h want 0", burst_o);
        else passed++;
        total++;
        if (line_o !== 256'd0) $display("FAIL reset_line got %h want 0", line_o);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_idle_resp();
        resp_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({resp_o, read_o, write_o} !== 3'b000) $display("FAIL idle_resp cyc %0d got %b want 000", i, {resp_o, read_o, write_o});
            else passed++;
        end
        resp_i = 1'b0;
        step();
    endtask

    task automatic test_read();
        logic [63:0] beats [4];
        beats[0] = 64'h1111_1111_1111_1111;
        beats[1] = 64'h2222_2222_2222_2222;
        beats[2] = 64'h3333_3333_3333_3333;
        beats[3] = 64'h4444_4444_4444_4444;
        address_i = 32'h0000_1234;
        read_i = 1'b1;
        step();
        read_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            total++;
            if (read_o !== 1'b1 || resp_o !== 1'b0) $display("FAIL read_o beat %0d got read_o=%b resp_o=%b want 1 0", b, read_o, resp_o);
            else passed++;
            total++;
            if (address_o !== 32'h0000_1220) $display("FAIL read_addr beat %0d got %h want 00001220", b, address_o);
            else passed++;
            burst_i = beats[b];
            resp_i = 1'b1;
            step();
        end
        resp_i = 1'b0;
        burst_i = 64'd0;
        total++;
        if (resp_o !== 1'b1 || read_o !== 1'b0) $display("FAIL read_done got resp_o=%b read_o=%b want 1 0", resp_o, read_o);
        else passed++;
        total++;
        if (line_o !== {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111})
            $display("FAIL read_line got %h want 44..33..22..11", line_o);
        else passed++;
        step();
        total++;
        if (resp_o !== 1'b0) $display("FAIL read_resp_single got %b want 0", resp_o);
        else passed++;
        total++;
        if (line_o !== {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111})
            $display("FAIL read_line_hold got %h want 44..33..22..11", line_o);
        else passed++;
    endtask

    task automatic test_write();
        logic [63:0] beats [4];
        int resp_seen;
        beats[0] = 64'hA;
        beats[1] = 64'hB;
        beats[2] = 64'hC;
        beats[3] = 64'hD;
        resp_seen = 0;
        line_i = {64'hD, 64'hC, 64'hB, 64'hA};
        address_i = 32'h8000_0040;
        write_i = 1'b1;
        step();
        write_i = 1'b0;
        line_i = '0;
        total++;
        if (address_o !== 32'h8000_0040) $display("FAIL write_addr got %h want 80000040", address_o);
        else passed++;
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < 3; g++) begin
                total++;
                if (burst_o !== beats[b] || write_o !== 1'b1) $display("FAIL write_beat %0d slot %0d got burst_o=%h write_o=%b want %h 1", b, g, burst_o, write_o, beats[b]);
                else passed++;
                if (resp_o) resp_seen++;
                resp_i = (g == 2);
                step();
            end
        end
        resp_i = 1'b0;
        total++;
        if (resp_seen !== 0) $display("FAIL write_early_resp got %0d want 0", resp_seen);
        else passed++;
        total++;
        if (resp_o !== 1'b1 || write_o !== 1'b0) $display("FAIL write_done got resp_o=%b write_o=%b want 1 0", resp_o, write_o);
        else passed++;
        step();
        total++;
        if (resp_o !== 1'b0) $display("FAIL write_resp_single got %b want 0", resp_o);
        else passed++;
        total++;
        if (line_o !== {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111})
            $display("FAIL write_keeps_line got %h want previous read line", line_o);
        else passed++;
    endtask

    task automatic test_both();
        int read_seen;
        read_seen = 0;
        line_i = {64'h4, 64'h3, 64'h2, 64'h1};
        address_i = 32'h0000_0100;
        read_i = 1'b1;
        write_i = 1'b1;
        step();
        read_i = 1'b0;
        write_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (read_o) read_seen++;
            total++;
            if (write_o !== 1'b1 || burst_o !== 64'(b + 1)) $display("FAIL both_write beat %0d got write_o=%b burst_o=%h want 1 %h", b, write_o, burst_o, 64'(b + 1));
            else passed++;
            resp_i = 1'b1;
            step();
        end
        resp_i = 1'b0;
        if (read_o) read_seen++;
        total++;
        if (read_seen !== 0) $display("FAIL both_no_read got %0d read cycles want 0", read_seen);
        else passed++;
        total++;
        if (resp_o !== 1'b1) $display("FAIL both_resp got %b want 1", resp_o);
        else passed++;
        step();
    endtask

    task automatic test_reset_mid();
        address_i = 32'h0000_2000;
        read_i = 1'b1;
        step();
        read_i = 1'b0;
        for (int b = 0; b < 2; b++) begin
            burst_i = 64'h5555_0000_0000_0000 + 64'(b);
            resp_i = 1'b1;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        resp_i = 1'b0;
        total++;
        if ({resp_o, read_o, write_o} !== 3'b000) $display("FAIL rst_mid_ctrl got %b want 000", {resp_o, read_o, write_o});
        else passed++;
        total++;
        if (line_o !== 256'd0 || address_o !== 32'd0) $display("FAIL rst_mid_data got line=%h addr=%h want 0 0", line_o, address_o);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (resp_o !== 1'b0 || read_o !== 1'b0) $display("FAIL rst_mid_quiet cyc %0d got resp_o=%b read_o=%b want 0 0", i, resp_o, read_o);
            else passed++;
        end
        address_i = 32'h0000_303F;
        read_i = 1'b1;
        step();
        read_i = 1'b0;
        total++;
        if (address_o !== 32'h0000_3020) $display("FAIL rst_fresh_addr got %h want 00003020", address_o);
        else passed++;
        for (int b = 0; b < 4; b++) begin
            burst_i = 64'hF0 + 64'(b);
            resp_i = 1'b1;
            step();
        end
        resp_i = 1'b0;
        total++;
        if (resp_o !== 1'b1) $display("FAIL rst_fresh_resp got %b want 1", resp_o);
        else passed++;
        total++;
        if (line_o !== {64'hF3, 64'hF2, 64'hF1, 64'hF0}) $display("FAIL rst_fresh_line got %h want F3 F2 F1 F0", line_o);
        else passed++;
        step();
    endtask

    task automatic test_held_read();
        int read_cycles;
        int resp_cycles;
        read_cycles = 0;
        resp_cycles = 0;
        address_i = 32'h0000_4000;
        read_i = 1'b1;
        step();
        for (int b = 0; b < 4; b++) begin
            if (read_o) read_cycles++;
            burst_i = 64'hBEEF_0000 + 64'(b);
            resp_i = 1'b1;
            step();
        end
        resp_i = 1'b0;
        total++;
        if (resp_o !== 1'b1) $display("FAIL held_resp got %b want 1", resp_o);
        else passed++;
        step();
        read_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (read_o) read_cycles++;
            if (resp_o) resp_cycles++;
            step();
        end
        total++;
        if (read_cycles !== 4) $display("FAIL held_read_cycles got %0d want 4", read_cycles);
        else passed++;
        total++;
        if (resp_cycles !== 0) $display("FAIL held_extra_resp got %0d want 0", resp_cycles);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total = 0;
        rst = 1'b1;
        line_i = '0;
        address_i = 32'd0;
        read_i = 1'b0;
        write_i = 1'b0;
        burst_i = 64'd0;
        resp_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_idle_resp();
        test_read();
        test_write();
        test_both();
        test_reset_mid();
        test_held_read();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
